// File: rtl/adc_serial_responder_pkg.sv
// Shared definitions for the serial ADC responder: link widths, FSM state
// encodings and the control-word field positions used by both ends of the link.
package adc_serial_responder_pkg;

    localparam int DATA_W   = 10;
    localparam int CTRL_W   = 10;
    localparam int CH_N     = 4;
    localparam int CONV_CYC = 100;

    localparam int CONV_EN_BIT = 2;
    localparam int CH_LSB      = 0;
    localparam int CH_MSB      = 1;
    localparam int CH_W        = CH_MSB - CH_LSB + 1;

    localparam int WCNT_W     = $clog2(CTRL_W + 1);
    localparam int CONV_CNT_W = $clog2(CONV_CYC);

    // Bit positions of the synchronised pins inside the top-level pin vector
    localparam int PIN_N    = 4;
    localparam int PIN_SCLK = 0;
    localparam int PIN_TFS  = 1;
    localparam int PIN_RFS  = 2;
    localparam int PIN_DIN  = 3;

    typedef enum logic       {W_IDLE, W_SHIFT}          w_state_e;
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE}   c_state_e;
    typedef enum logic       {R_IDLE, R_SHIFT}          r_state_e;

endpackage

// File: rtl/adc_serial_responder_edge_sync.sv
// Two-flop synchroniser for one link pin plus a third flop for edge detection.
// All flops reset low so a sync line already low at reset release never looks like a fresh fall.
module adc_serial_responder_edge_sync (
    input  logic clk_clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], pin_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc_serial_responder.sv
// Far-end model of the four-channel serial ADC: accepts control words on DIN/TFS,
// runs a fixed-latency conversion and returns the result on DOUT/RFS.
module adc_serial_responder
    import adc_serial_responder_pkg::*;
(
    input  logic                     clk_clk,
    input  logic                     reset_n,
    input  logic                     sclk,
    input  logic                     tfs,
    input  logic                     rfs,
    input  logic                     din,
    output logic                     dout,
    input  logic [CH_N*DATA_W-1:0]   ch_sample,
    output logic                     busy,
    output logic [CTRL_W-1:0]        ctrl_word,
    output logic [DATA_W-1:0]        result,
    output logic                     frame_err
);

    localparam logic [WCNT_W-1:0]     WCNT_FULL = WCNT_W'(CTRL_W);
    localparam logic [CONV_CNT_W-1:0] CONV_LOAD = CONV_CNT_W'(CONV_CYC - 1);

    logic [PIN_N-1:0] pin_raw, pin_lvl, pin_rise, pin_fall;

    assign pin_raw = {din, rfs, tfs, sclk};

    for (genvar gi = 0; gi < PIN_N; gi++) begin : g_sync
        adc_serial_responder_edge_sync u_sync (
            .clk_clk (clk_clk),
            .reset_n (reset_n),
            .pin_i   (pin_raw[gi]),
            .level_o (pin_lvl[gi]),
            .rise_o  (pin_rise[gi]),
            .fall_o  (pin_fall[gi])
        );
    end

    logic unused_sync;
    assign unused_sync = ^{pin_lvl[PIN_SCLK], pin_lvl[PIN_RFS], pin_rise[PIN_DIN], pin_fall[PIN_DIN]};

    logic [DATA_W-1:0] samples [CH_N];

    for (genvar gi = 0; gi < CH_N; gi++) begin : g_samples
        assign samples[gi] = ch_sample[gi*DATA_W +: DATA_W];
    end

    // ---------------- write path ----------------
    w_state_e          w_state_q;
    logic [CTRL_W-1:0] wr_shift_q;
    logic [WCNT_W-1:0] wr_cnt_q;
    logic [CTRL_W-1:0] ctrl_word_q;
    logic              frame_err_q;
    logic              ctrl_latch;

    assign ctrl_latch = (w_state_q == W_SHIFT) && pin_rise[PIN_TFS] && (wr_cnt_q == WCNT_FULL);

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q   <= W_IDLE;
            wr_shift_q  <= '0;
            wr_cnt_q    <= '0;
            ctrl_word_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (pin_fall[PIN_TFS]) begin
                        w_state_q <= W_SHIFT;
                        wr_cnt_q  <= '0;
                    end
                end
                W_SHIFT: begin
                    if (pin_rise[PIN_TFS]) begin
                        w_state_q <= W_IDLE;
                        if (wr_cnt_q == WCNT_FULL) begin
                            ctrl_word_q <= wr_shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (pin_fall[PIN_SCLK] && !pin_lvl[PIN_TFS] && (wr_cnt_q < WCNT_FULL)) begin
                        // Counter stops at a full word, so trailing bits never disturb it
                        wr_shift_q <= {wr_shift_q[CTRL_W-2:0], pin_lvl[PIN_DIN]};
                        wr_cnt_q   <= wr_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- conversion ----------------
    c_state_e              c_state_q;
    logic [CONV_CNT_W-1:0] conv_cnt_q;
    logic [CH_W-1:0]       conv_ch_q;
    logic                  busy_q;
    logic [DATA_W-1:0]     result_q;

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            c_state_q  <= C_IDLE;
            conv_cnt_q <= '0;
            conv_ch_q  <= '0;
            busy_q     <= 1'b0;
            result_q   <= '0;
        end else if (ctrl_latch && wr_shift_q[CONV_EN_BIT]) begin
            // A new request always wins, abandoning any conversion in flight
            c_state_q  <= C_BUSY;
            conv_cnt_q <= CONV_LOAD;
            conv_ch_q  <= wr_shift_q[CH_MSB:CH_LSB];
            busy_q     <= 1'b1;
        end else begin
            case (c_state_q)
                C_BUSY: begin
                    if (conv_cnt_q == '0) begin
                        result_q  <= samples[conv_ch_q];
                        busy_q    <= 1'b0;
                        c_state_q <= C_DONE;
                    end else begin
                        conv_cnt_q <= conv_cnt_q - 1'b1;
                    end
                end
                C_DONE: begin
                    if (pin_fall[PIN_RFS]) begin
                        c_state_q <= C_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_e          r_state_q;
    logic [DATA_W-1:0] rd_shift_q;
    logic              dout_q;

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q  <= R_IDLE;
            rd_shift_q <= '0;
            dout_q     <= 1'b0;
        end else begin
            // Extra output stage keeps DOUT launch timing identical for every bit
            dout_q <= rd_shift_q[DATA_W-1];
            case (r_state_q)
                R_IDLE: begin
                    if (pin_fall[PIN_RFS]) begin
                        rd_shift_q <= result_q;
                        r_state_q  <= R_SHIFT;
                    end
                end
                R_SHIFT: begin
                    if (pin_rise[PIN_RFS]) begin
                        rd_shift_q <= '0;
                        r_state_q  <= R_IDLE;
                    end else if (pin_rise[PIN_SCLK]) begin
                        rd_shift_q <= {rd_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign ctrl_word = ctrl_word_q;
    assign result    = result_q;
    assign frame_err = frame_err_q;

endmodule
